// File: rtl/forward_registered_v3_pkg.sv
// Shared constants for the forward-registered stream channel.
// Default word width/depth and the counter width helper.
package forward_registered_v3_pkg;

  localparam int WIDTH_DEF = 9;
  localparam int DEPTH_DEF = 256;

  // Counter must hold the value DEPTH itself.
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/fwd_reg_slice_v3.sv
// Forward-registered slice: registers valid/data, ready is combinational.
// Ports: clk, rst_n, in_* upstream link, out_* downstream link.
module fwd_reg_slice_v3 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  // Room exists when empty or when the held word drains this edge.
  assign in_ready = out_ready || !out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_data  <= in_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/handshake_sink_v3.sv
// Checking sink: captures words, checks sequence, counts accepts.
// Ports: clk, rst_n, accept -> ready, valid/data in, rx_count/err/done.
module handshake_sink_v3
  import forward_registered_v3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      accept,
  input  logic                      valid,
  output logic                      ready,
  input  logic [WIDTH-1:0]          data,
  output logic [cnt_w(DEPTH)-1:0]   rx_count,
  output logic                      err,
  output logic                      done
);

  localparam int CW = cnt_w(DEPTH);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] exp_val;
  logic [AW-1:0]    addr;
  logic             xfer;
  logic             seq_bad;

  // Readback of the previous capture guards the memory itself.
  logic             chk_pend;
  logic [AW-1:0]    chk_addr;
  logic [WIDTH-1:0] chk_val;
  logic             mem_bad;

  assign ready   = accept;
  assign xfer    = valid && ready;
  assign addr    = rx_count[AW-1:0];
  assign seq_bad = xfer && (data != exp_val);
  assign mem_bad = chk_pend && (mem[chk_addr] != chk_val);

  always_ff @(posedge clk) begin
    if (xfer)
      mem[addr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_val  <= '0;
      rx_count <= '0;
      err      <= 1'b0;
      done     <= 1'b0;
      chk_pend <= 1'b0;
      chk_addr <= '0;
      chk_val  <= '0;
    end else begin
      chk_pend <= xfer;
      if (xfer) begin
        chk_addr <= addr;
        chk_val  <= data;
        exp_val  <= (exp_val == WIDTH'(DEPTH - 1)) ?
                    '0 : exp_val + 1'b1;
        if (rx_count != CW'(DEPTH))
          rx_count <= rx_count + 1'b1;
        if (rx_count == CW'(DEPTH - 1))
          done <= 1'b1;
      end
      if (seq_bad || mem_bad)
        err <= 1'b1;
    end
  end

endmodule

// File: rtl/handshake_source_v3.sv
// Counting source: offers 0,1,2.. wrapping at DEPTH, valid held until taken.
// Ports: clk, rst_n, offer -> valid/data out, ready in.
module handshake_source_v3
  import forward_registered_v3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             offer,
  output logic             valid,
  input  logic             ready,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] cnt;
  logic             xfer;

  assign xfer = valid && ready;
  assign data = cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      cnt   <= '0;
    end else begin
      if (xfer)
        cnt <= (cnt == WIDTH'(DEPTH - 1)) ? '0 : cnt + 1'b1;
      // A pending word is never withdrawn.
      if (!valid || xfer)
        valid <= offer;
    end
  end

endmodule

// File: rtl/forward_registered_v3.sv
// Source -> forward-registered slice -> checking sink, one clock domain.
// Pins: offer/accept controls, both links' handshakes, checker status.
module forward_registered_v3
  import forward_registered_v3_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    s_rst,
  input  logic                    vaild_in,
  input  logic                    ready_in,
  output logic                    src_vaild,
  output logic                    src_ready,
  output logic [WIDTH-1:0]        src_data,
  output logic                    dst_vaild,
  output logic                    dst_ready,
  output logic [WIDTH-1:0]        dst_data,
  output logic [cnt_w(DEPTH)-1:0] rx_count,
  output logic                    err,
  output logic                    done
);

  handshake_source_v3 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_src (
    .clk  (clk),
    .rst_n(s_rst),
    .offer(vaild_in),
    .valid(src_vaild),
    .ready(src_ready),
    .data (src_data)
  );

  fwd_reg_slice_v3 #(
    .WIDTH(WIDTH)
  ) u_slice (
    .clk      (clk),
    .rst_n    (s_rst),
    .in_valid (src_vaild),
    .in_ready (src_ready),
    .in_data  (src_data),
    .out_valid(dst_vaild),
    .out_ready(dst_ready),
    .out_data (dst_data)
  );

  handshake_sink_v3 #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) u_sink (
    .clk     (clk),
    .rst_n   (s_rst),
    .accept  (ready_in),
    .valid   (dst_vaild),
    .ready   (dst_ready),
    .data    (dst_data),
    .rx_count(rx_count),
    .err     (err),
    .done    (done)
  );

endmodule

// File: tb/tb_forward_registered_v3.sv
// Directed bench for forward_registered_v3.
// Scoreboards the sink link and checks reset, stream, stall, bubble.
module tb_forward_registered_v3;

  logic       clk = 1'b0;
  logic       s_rst;
  logic       vaild_in;
  logic       ready_in;
  logic       src_vaild;
  logic       src_ready;
  logic [8:0] src_data;
  logic       dst_vaild;
  logic       dst_ready;
  logic [8:0] dst_data;
  logic [8:0] rx_count;
  logic       err;
  logic       done;

  int errors = 0;
  int checks = 0;
  int hs = 0;
  int exp_seq = 0;

  forward_registered_v3 dut (
    .clk      (clk),
    .s_rst    (s_rst),
    .vaild_in (vaild_in),
    .ready_in (ready_in),
    .src_vaild(src_vaild),
    .src_ready(src_ready),
    .src_data (src_data),
    .dst_vaild(dst_vaild),
    .dst_ready(dst_ready),
    .dst_data (dst_data),
    .rx_count (rx_count),
    .err      (err),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Scoreboard the upcoming edge, then step to just after it.
  task automatic tick();
    if (s_rst && dst_vaild && dst_ready) begin
      chk("seq", 32'(dst_data), 32'(exp_seq));
      hs++;
      exp_seq = (exp_seq + 1) % 256;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic hold_reset(input int n);
    s_rst = 1'b0;
    hs = 0;
    exp_seq = 0;
    repeat (n) tick();
  endtask

  initial begin
    int seen;
    int lim;
    s_rst = 1'b0;
    vaild_in = 1'b0;
    ready_in = 1'b0;

    // Reset with random pins
    hold_reset(1);
    repeat (4) begin
      vaild_in = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rst_src_v", 32'(src_vaild), 0);
    chk("rst_src_d", 32'(src_data), 0);
    chk("rst_dst_v", 32'(dst_vaild), 0);
    chk("rst_dst_d", 32'(dst_data), 0);
    chk("rst_cnt", 32'(rx_count), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_done", 32'(done), 0);

    vaild_in = 1'b0;
    ready_in = 1'b1;
    s_rst = 1'b1;
    repeat (3) tick();
    chk("idle_src_v", 32'(src_vaild), 0);
    chk("idle_dst_v", 32'(dst_vaild), 0);

    // Full streaming
    hold_reset(1);
    vaild_in = 1'b1;
    ready_in = 1'b1;
    s_rst = 1'b1;
    tick();
    chk("fs_src_v1", 32'(src_vaild), 1);
    chk("fs_src_d1", 32'(src_data), 0);
    chk("fs_dst_v1", 32'(dst_vaild), 0);
    tick();
    chk("fs_dst_v2", 32'(dst_vaild), 1);
    chk("fs_dst_d2", 32'(dst_data), 0);
    chk("fs_src_d2", 32'(src_data), 1);
    lim = 0;
    while (hs < 256 && lim < 300) begin
      tick();
      lim++;
    end
    chk("fs_bound", 32'(hs), 256);
    chk("fs_done", 32'(done), 1);
    chk("fs_err", 32'(err), 0);
    chk("fs_cnt", 32'(rx_count), 256);
    chk("fs_wrap_v", 32'(dst_vaild), 1);
    chk("fs_wrap_d", 32'(dst_data), 0);
    repeat (3) tick();
    chk("fs_sat", 32'(rx_count), 256);

    // Backpressure
    hold_reset(1);
    s_rst = 1'b1;
    repeat (9) tick();
    chk("bp_pre_d", 32'(dst_data), 7);
    ready_in = 1'b0;
    repeat (5) begin
      tick();
      chk("bp_dst_v", 32'(dst_vaild), 1);
      chk("bp_dst_d", 32'(dst_data), 7);
      chk("bp_src_r", 32'(src_ready), 0);
      chk("bp_src_v", 32'(src_vaild), 1);
      chk("bp_src_d", 32'(src_data), 8);
    end
    ready_in = 1'b1;
    tick();
    chk("bp_r1_v", 32'(dst_vaild), 1);
    chk("bp_r1_d", 32'(dst_data), 8);
    tick();
    chk("bp_r2_v", 32'(dst_vaild), 1);
    chk("bp_r2_d", 32'(dst_data), 9);
    chk("bp_err", 32'(err), 0);

    // Random pins
    hold_reset(1);
    s_rst = 1'b1;
    repeat (300) begin
      vaild_in = 1'($urandom_range(0, 1));
      ready_in = 1'($urandom_range(0, 1));
      tick();
    end
    chk("rnd_err", 32'(err), 0);
    seen = (hs > 256) ? 256 : hs;
    chk("rnd_cnt", 32'(rx_count), 32'(seen));
    for (int i = 0; i < seen; i++)
      chk("rnd_mem", 32'(dut.u_sink.mem[i]), 32'(i));

    // Single-word bubble
    vaild_in = 1'b0;
    ready_in = 1'b1;
    hold_reset(1);
    s_rst = 1'b1;
    repeat (2) tick();
    vaild_in = 1'b1;
    tick();
    vaild_in = 1'b0;
    seen = 0;
    repeat (6) begin
      tick();
      if (dst_vaild) seen++;
    end
    chk("bub_vcyc", 32'(seen), 1);
    chk("bub_words", 32'(hs), 1);
    chk("bub_cnt", 32'(rx_count), 1);

    // Reset mid-transfer
    hold_reset(1);
    s_rst = 1'b1;
    vaild_in = 1'b1;
    ready_in = 1'b0;
    repeat (4) tick();
    chk("mid_pre_v", 32'(dst_vaild), 1);
    #2;
    s_rst = 1'b0;
    hs = 0;
    exp_seq = 0;
    #1;
    chk("mid_async_dv", 32'(dst_vaild), 0);
    chk("mid_async_sv", 32'(src_vaild), 0);
    tick();
    ready_in = 1'b1;
    s_rst = 1'b1;
    repeat (12) tick();
    chk("mid_words", 32'(hs), 10);
    chk("mid_cnt", 32'(rx_count), 10);
    chk("mid_err", 32'(err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
